// File: rtl/link_mm_pkg.sv
// Shared types and constants for the link MM initiator.
// The timeout pattern helper keeps the error word layout in one place.
package link_mm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RSP     = 2'd2
    } mm_init_state_t;

    localparam logic [31:0] TIMEOUT_TAG = 32'hDEAD_0BAD;

    // Upper word marks the abort, lower word names the address that never answered.
    function automatic logic [63:0] timeout_word(input logic [31:0] addr32);
        return {TIMEOUT_TAG, addr32};
    endfunction

endpackage

// File: rtl/mm_sat_cnt.sv
// Saturating event counter: increments on i_inc and sticks at all-ones.
module mm_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_cnt <= '0;
        end else if (i_inc && (o_cnt != {CNT_W{1'b1}})) begin
            o_cnt <= o_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/link_mm_initiator.sv
// Host-request to MM-strobe bridge for the link address decoder: posted writes,
// one outstanding read with timeout, completions returned on a valid/ready port.
module link_mm_initiator
    import link_mm_pkg::*;
#(
    parameter int ADDR_W      = 17,
    parameter int TIMEOUT_CYC = 256,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_data,
    output logic              rsp_err,
    output logic              oMM_WR_EN,
    output logic              oMM_RD_EN,
    output logic [ADDR_W-1:0] oMM_ADDR,
    output logic [63:0]       oMM_WR_DATA,
    input  logic [63:0]       iMM_RD_DATA,
    input  logic              iMM_RD_DATA_V,
    output logic [CNT_W-1:0]  timeout_cnt,
    output logic [CNT_W-1:0]  stray_cnt
);

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYC - 1);

    mm_init_state_t    r_state;
    mm_init_state_t    w_state_nxt;
    logic [15:0]       r_timer;
    logic              r_req_ready;
    logic              r_wr_en;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_addr;
    logic [63:0]       r_wdata;
    logic              r_rsp_valid;
    logic [63:0]       r_rsp_data;
    logic              r_rsp_err;

    logic              w_accept;
    logic              w_rsp_hs;
    logic              w_timer_done;
    logic              w_timeout_inc;
    logic              w_stray_inc;
    logic [31:0]       w_addr32;

    assign req_ready   = r_req_ready;
    assign oMM_WR_EN   = r_wr_en;
    assign oMM_RD_EN   = r_rd_en;
    assign oMM_ADDR    = r_addr;
    assign oMM_WR_DATA = r_wdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_err     = r_rsp_err;

    always_comb begin
        w_accept      = req_valid & r_req_ready;
        w_rsp_hs      = r_rsp_valid & rsp_ready;
        w_timer_done  = (r_timer == TIMER_LAST);
        w_addr32      = 32'(r_addr);
        w_state_nxt   = r_state;
        w_timeout_inc = 1'b0;
        // Only RD_WAIT is expecting data; anything else is late or spurious.
        w_stray_inc   = iMM_RD_DATA_V && (r_state != RD_WAIT);
        case (r_state)
            IDLE: begin
                if (w_accept && !req_wr) begin
                    w_state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (iMM_RD_DATA_V) begin
                    w_state_nxt = RSP;
                end else if (w_timer_done) begin
                    w_state_nxt   = RSP;
                    w_timeout_inc = 1'b1;
                end
            end
            RSP: begin
                if (w_rsp_hs) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_req_ready <= 1'b0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == IDLE);
            r_wr_en     <= w_accept & req_wr;
            r_rd_en     <= w_accept & ~req_wr;
            if (w_accept) begin
                r_addr <= req_addr;
            end
            if (w_accept && req_wr) begin
                r_wdata <= req_wdata;
            end
            r_timer <= (r_state == RD_WAIT) ? r_timer + 16'd1 : 16'd0;

            // Data beats the timeout when both land in the terminal cycle.
            if (r_state == RD_WAIT) begin
                if (iMM_RD_DATA_V) begin
                    r_rsp_data  <= iMM_RD_DATA;
                    r_rsp_err   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                end else if (w_timer_done) begin
                    r_rsp_data  <= timeout_word(w_addr32);
                    r_rsp_err   <= 1'b1;
                    r_rsp_valid <= 1'b1;
                end
            end else if (w_rsp_hs) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    mm_sat_cnt #(.CNT_W(CNT_W)) u_timeout_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_timeout_inc),
        .o_cnt (timeout_cnt)
    );

    mm_sat_cnt #(.CNT_W(CNT_W)) u_stray_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_stray_inc),
        .o_cnt (stray_cnt)
    );

endmodule

// File: tb/tb_link_mm_initiator.sv
// Directed plus randomized bench for link_mm_initiator against a transaction-level model.
module tb_link_mm_initiator;

    localparam int ADDR_W = 17;
    localparam int TO     = 8;
    localparam int CNT_W  = 3;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_wr = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [63:0]       req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [63:0]       rsp_data;
    logic              rsp_err;
    logic              oMM_WR_EN;
    logic              oMM_RD_EN;
    logic [ADDR_W-1:0] oMM_ADDR;
    logic [63:0]       oMM_WR_DATA;
    logic [63:0]       iMM_RD_DATA = '0;
    logic              iMM_RD_DATA_V = 1'b0;
    logic [CNT_W-1:0]  timeout_cnt;
    logic [CNT_W-1:0]  stray_cnt;

    int checks = 0;
    int failures = 0;
    int exp_to = 0;
    int exp_stray = 0;

    link_mm_initiator #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .oMM_WR_EN     (oMM_WR_EN),
        .oMM_RD_EN     (oMM_RD_EN),
        .oMM_ADDR      (oMM_ADDR),
        .oMM_WR_DATA   (oMM_WR_DATA),
        .iMM_RD_DATA   (iMM_RD_DATA),
        .iMM_RD_DATA_V (iMM_RD_DATA_V),
        .timeout_cnt   (timeout_cnt),
        .stray_cnt     (stray_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [63:0] d);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d;
        tick();
        req_valid = 1'b0;
        chk("wr_en", 64'(oMM_WR_EN), 64'd1);
        chk("wr_addr", 64'(oMM_ADDR), 64'(a));
        chk("wr_data", oMM_WR_DATA, d);
        chk("wr_no_rsp", 64'(rsp_valid), 64'd0);
        chk("wr_ready", 64'(req_ready), 64'd1);
        tick();
        chk("wr_en_drop", 64'(oMM_WR_EN), 64'd0);
    endtask

    task automatic stray_idle();
        iMM_RD_DATA_V = 1'b1; iMM_RD_DATA = 64'($urandom);
        tick();
        iMM_RD_DATA_V = 1'b0;
        exp_stray = sat_inc(exp_stray);
        chk("stray_idle_cnt", 64'(stray_cnt), 64'(exp_stray));
        chk("stray_idle_rsp", 64'(rsp_valid), 64'd0);
    endtask

    // lat < TO: decoder answers in that wait cycle; lat >= TO: never answers.
    task automatic do_read(input logic [ADDR_W-1:0] a, input int lat, input int hold,
                           input logic [63:0] rdata, input bit late);
        logic [63:0] exp_data;
        logic        exp_err;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = a;
        tick();
        req_valid = 1'b0;
        chk("rd_en", 64'(oMM_RD_EN), 64'd1);
        chk("rd_addr", 64'(oMM_ADDR), 64'(a));
        chk("rd_ready_low", 64'(req_ready), 64'd0);
        for (int k = 0; k < TO; k++) begin
            if (k == lat) begin
                iMM_RD_DATA_V = 1'b1; iMM_RD_DATA = rdata;
            end
            tick();
            iMM_RD_DATA_V = 1'b0;
            if (k == lat) break;
            if (k < TO - 1) chk("rd_wait_idle", 64'(rsp_valid), 64'd0);
        end
        if (lat < TO) begin
            exp_data = rdata;
            exp_err  = 1'b0;
        end else begin
            exp_data = {32'hDEAD0BAD, 32'(a)};
            exp_err  = 1'b1;
            exp_to   = sat_inc(exp_to);
        end
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_err", 64'(rsp_err), 64'(exp_err));
        chk("timeout_cnt", 64'(timeout_cnt), 64'(exp_to));
        if (late) begin
            iMM_RD_DATA_V = 1'b1; iMM_RD_DATA = ~rdata;
            tick();
            iMM_RD_DATA_V = 1'b0;
            exp_stray = sat_inc(exp_stray);
            chk("late_stray_cnt", 64'(stray_cnt), 64'(exp_stray));
            chk("late_rsp_data", rsp_data, exp_data);
            chk("late_rsp_err", 64'(rsp_err), 64'(exp_err));
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_valid", 64'(rsp_valid), 64'd1);
            chk("hold_data", rsp_data, exp_data);
            chk("hold_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_drop", 64'(rsp_valid), 64'd0);
        chk("rsp_back_idle", 64'(req_ready), 64'd1);
    endtask

    initial begin
        logic [ADDR_W-1:0] ra;
        logic [63:0]       rd;
        int                lat;

        // Reset state
        #12;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_wr_en", 64'(oMM_WR_EN), 64'd0);
        chk("rst_rd_en", 64'(oMM_RD_EN), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_to_cnt", 64'(timeout_cnt), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", 64'(req_ready), 64'd1);

        do_write(17'h0_4010, 64'h1122_3344_5566_7788);

        // Four back-to-back writes with req_valid held
        req_valid = 1'b1; req_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr  = 17'(i * 8 + 3);
            req_wdata = 64'h1000 + 64'(i);
            tick();
            chk("b2b_wr_en", 64'(oMM_WR_EN), 64'd1);
            chk("b2b_addr", 64'(oMM_ADDR), 64'(i * 8 + 3));
            chk("b2b_data", oMM_WR_DATA, 64'h1000 + 64'(i));
            chk("b2b_ready", 64'(req_ready), 64'd1);
        end
        req_valid = 1'b0;
        tick();
        chk("b2b_end", 64'(oMM_WR_EN), 64'd0);

        do_read(17'h0_8000, 3, 5, 64'hCAFE, 1'b0);
        do_read(17'h0_8000, TO, 0, 64'h0, 1'b1);
        do_read(17'h1_2345, TO - 1, 1, 64'h0BAD_F00D_1234_5678, 1'b0);
        stray_idle();

        // Reset during RD_WAIT
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 17'h0_0ABC;
        tick();
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        exp_to = 0; exp_stray = 0;
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_rd_en", 64'(oMM_RD_EN), 64'd0);
        chk("mid_rst_addr", 64'(oMM_ADDR), 64'd0);
        chk("mid_rst_rsp", 64'(rsp_valid), 64'd0);
        chk("mid_rst_to_cnt", 64'(timeout_cnt), 64'd0);
        chk("mid_rst_stray", 64'(stray_cnt), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 64'(req_ready), 64'd1);
        stray_idle();
        do_read(17'h0_0ABC, 2, 0, 64'h5555_AAAA_0000_FFFF, 1'b0);

        // Saturation of both counters
        for (int i = 0; i < CMAX + 2; i++) do_read(17'(i), TO, 0, 64'h0, 1'b1);

        // Randomized mix
        for (int n = 0; n < 40; n++) begin
            ra = 17'($urandom);
            rd = {$urandom, $urandom};
            case ($urandom_range(0, 2))
                0: do_write(ra, rd);
                1: begin
                    lat = int'($urandom_range(0, TO + 1));
                    do_read(ra, lat, int'($urandom_range(0, 3)), rd, (lat >= TO) && ($urandom_range(0, 1) == 1));
                end
                default: stray_idle();
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
